// File: rtl/md_if.sv
// E-stage command/result bundle between the pipeline and the multiply/divide unit.
// The master drives the decoded op and operands; the slave returns start/busy and the HI/LO read value.
interface md_if;
  logic [3:0]  hilo_type;
  logic        valid;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        start;
  logic        busy;
  logic [31:0] hilo_out;

  modport master (
    output hilo_type, valid, src_a, src_b,
    input  start, busy, hilo_out
  );

  modport slave (
    input  hilo_type, valid, src_a, src_b,
    output start, busy, hilo_out
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with private HI/LO, serving mf/mt moves.
// Define MDU_MADD_EN to enable the madd/maddu/msub/msubu accumulate ops (codes 8-11).
//
// state | meaning
// IDLE  | accepts md ops and mthi/mtlo
// RUN   | result held in hi_nx/lo_nx, counting down to commit
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset_n,
  md_if.slave  md
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MFHI  = 4'd4;
  localparam logic [3:0] OP_MFLO  = 4'd5;
  localparam logic [3:0] OP_MTHI  = 4'd6;
  localparam logic [3:0] OP_MTLO  = 4'd7;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd8;
  localparam logic [3:0] OP_MADDU = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd10;
  localparam logic [3:0] OP_MSUBU = 4'd11;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_nx_q, hi_nx_d;
  logic [31:0] lo_nx_q, lo_nx_d;
  logic        commit_q, commit_d;

  logic        busy;
  logic        start;
  logic        is_md;
  logic        is_mul;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        div_zero;
  logic [31:0] div_s_q, div_s_r;
  logic [31:0] div_u_q, div_u_r;
  logic [31:0] hilo_rd;
`ifdef MDU_MADD_EN
  logic [63:0] acc;
`endif

  assign busy = (state_q == RUN);

  always_comb begin
    is_md  = 1'b0;
    is_mul = 1'b0;
    case (md.hilo_type)
      OP_MULT, OP_MULTU: begin
        is_md  = 1'b1;
        is_mul = 1'b1;
      end
      OP_DIV, OP_DIVU: is_md = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
        is_md  = 1'b1;
        is_mul = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign start = md.valid & ~busy & is_md;

  always_comb begin
    prod_s = {{32{md.src_a[31]}}, md.src_a} * {{32{md.src_b[31]}}, md.src_b};
    prod_u = {32'd0, md.src_a} * {32'd0, md.src_b};
  end

  // Divisor forced to 1 on divide-by-zero so the dividers never see 0; the result is discarded anyway.
  always_comb begin
    logic [31:0] dvs;
    div_zero = (md.src_b == 32'd0);
    dvs      = div_zero ? 32'd1 : md.src_b;
    div_u_q  = md.src_a / dvs;
    div_u_r  = md.src_a % dvs;
    if (md.src_a == 32'h8000_0000 && dvs == 32'hFFFF_FFFF) begin
      div_s_q = 32'h8000_0000;
      div_s_r = 32'd0;
    end else begin
      div_s_q = $signed(md.src_a) / $signed(dvs);
      div_s_r = $signed(md.src_a) % $signed(dvs);
    end
  end

`ifdef MDU_MADD_EN
  assign acc = {hi_q, lo_q};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_nx_d  = hi_nx_q;
    lo_nx_d  = lo_nx_q;
    commit_d = commit_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          cnt_d    = is_mul ? MULT_CNT : DIV_CNT;
          commit_d = 1'b1;
          case (md.hilo_type)
            OP_MULT:  {hi_nx_d, lo_nx_d} = prod_s;
            OP_MULTU: {hi_nx_d, lo_nx_d} = prod_u;
            OP_DIV: begin
              hi_nx_d  = div_s_r;
              lo_nx_d  = div_s_q;
              commit_d = ~div_zero;
            end
            OP_DIVU: begin
              hi_nx_d  = div_u_r;
              lo_nx_d  = div_u_q;
              commit_d = ~div_zero;
            end
`ifdef MDU_MADD_EN
            OP_MADD:  {hi_nx_d, lo_nx_d} = acc + prod_s;
            OP_MADDU: {hi_nx_d, lo_nx_d} = acc + prod_u;
            OP_MSUB:  {hi_nx_d, lo_nx_d} = acc - prod_s;
            OP_MSUBU: {hi_nx_d, lo_nx_d} = acc - prod_u;
`endif
            default: ;
          endcase
        end else if (md.valid && md.hilo_type == OP_MTHI) begin
          hi_d = md.src_a;
        end else if (md.valid && md.hilo_type == OP_MTLO) begin
          lo_d = md.src_a;
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        // <= rather than == so a zero-cycle parameter cannot wrap the counter and hang in RUN.
        if (cnt_q <= 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          if (commit_q) begin
            hi_d = hi_nx_q;
            lo_d = lo_nx_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      hi_nx_q  <= 32'd0;
      lo_nx_q  <= 32'd0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_nx_q  <= hi_nx_d;
      lo_nx_q  <= lo_nx_d;
      commit_q <= commit_d;
    end
  end

  always_comb begin
    hilo_rd = 32'd0;
    case (md.hilo_type)
      OP_MFHI: hilo_rd = hi_q;
      OP_MFLO: hilo_rd = lo_q;
      default: ;
    endcase
  end

  assign md.start    = start;
  assign md.busy     = busy;
  assign md.hilo_out = hilo_rd;

endmodule

// File: doc/md_unit.md
# md_unit

Execute-stage multiply/divide unit. It consumes the `HILOType` code and operands that the control decoder emits for E stage. It runs multi-cycle mult/div operations against private HI/LO registers and serves `mfhi`/`mflo`/`mthi`/`mtlo`. It exports `start`/`busy` so the hazard unit can stall D-stage md/mf/mt instructions while an operation is in flight.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (and madd family when enabled).
- `DIV_CYCLES`, default 10: busy cycles for div/divu.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, input, 1: rising-edge clock.
- `reset_n`, input, 1: asynchronous active-low reset.
- `hilo_type`, input, 4: E-stage operation code.
  - 0 mult, 1 multu, 2 div, 3 divu.
  - 4 mfhi, 5 mflo, 6 mthi, 7 mtlo.
  - 8–11 madd/maddu/msub/msubu.
  - 15 none.
- `valid`, input, 1: E-stage instruction is real, i.e. not a bubble or flushed.
- `src_a`, input, 32: rs operand.
- `src_b`, input, 32: rt operand.
- `start`, output, 1: combinational; high when an md op is accepted this cycle.
- `busy`, output, 1: registered; high while an accepted op is computing.
- `hilo_out`, output, 32: combinational read value. HI for code 4, LO for code 5, otherwise 0.

## Operation
- State is IDLE or RUN, with a counter `cnt` of 4 bits, plus `HI`, `LO`, `hi_nx`, `lo_nx`.
- Accept rule: `start = valid & ~busy & hilo_type ∈ {0,1,2,3}` (plus 8–11 when configured).
- On accept:
  - Compute the result at the accepting edge into `hi_nx`/`lo_nx`.
  - Load `cnt = MULT_CYCLES` or `DIV_CYCLES`.
  - Go to RUN.
- RUN:
  - `cnt` decrements each edge.
  - On the edge where `cnt == 1`, commit `HI <= hi_nx` and `LO <= lo_nx`, then return to IDLE.
- mult: {HI,LO} = signed 64-bit product.
- multu: {HI,LO} = unsigned 64-bit product.
- div/divu:
  - LO = quotient, truncated toward zero.
  - HI = remainder, carrying the sign of the dividend for div.
- Divide by zero: no commit. HI and LO are unchanged, but the full busy period still elapses.
- div with 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- mthi/mtlo:
  - When `valid & ~busy`, write `src_a` to HI or LO at the edge, with no busy period.
  - While busy, they are ignored.
- Any command arriving while busy (md, mt) is ignored with no state change. The hazard unit guarantees this never happens legitimately.
- Codes 12–14 and 15 are no-ops.
- mfhi/mflo read HI/LO combinationally in any state. The hazard unit guarantees mf is not issued while busy or start.

## Timing
- Reset: HI = 0, LO = 0, busy = 0, cnt = 0, state IDLE. `start` and `hilo_out` follow from these.
- Reset asserted mid-RUN aborts the operation, discards `hi_nx`/`lo_nx`, and clears busy immediately (asynchronously).
- md accepted in cycle T:
  - `start` is high in T.
  - `busy` is high in T+1 … T+N (N = 5 or 10).
  - HI/LO show the new values from T+N+1, which is also when `busy` falls.
- Back-to-back: the earliest next accept is cycle T+N+1.
- mthi in cycle T: HI updates at the end of T, and mfhi in T+1 reads the new value.
- start and busy are never both high.

## Configuration
- `MDU_MADD_EN` defined:
  - Codes 8/9 add the signed/unsigned 64-bit product to {HI,LO}.
  - Codes 10/11 subtract it.
  - Arithmetic is modulo 2^64 and uses the {HI,LO} value at the accepting edge.
  - Latency is `MULT_CYCLES`.
- `MDU_MADD_EN` undefined: codes 8–11 are no-ops. `start` stays low, and there is no busy and no state change.

## Test plan
- Signed mult:
  - Stimulus: mult with A=0xFFFFFFFE (−2), B=3 at cycle T.
  - Required: start=1 in T; busy in T+1…T+5; from T+6 HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- Signed div:
  - Stimulus: div with A=−7 (0xFFFFFFF9), B=2.
  - Required: busy for 10 cycles; then LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
  - Follow-up: divu with the same operands gives LO=0x7FFFFFFC, HI=1.
- Divide by zero and ignore-while-busy:
  - Stimulus: mthi 0x1234, then divu by 0; at busy cycle 3 issue mtlo 0x55.
  - Required: after 10 cycles HI=0x1234 and LO is unchanged (mtlo ignored).
- Async reset mid-run:
  - Stimulus: mult 0x10000 × 0x10000, then assert `reset_n` low at busy cycle 2.
  - Required: busy=0, HI=LO=0 immediately. After release, the unit is idle and accepts a new mult.
- Valid gating and mt/mf:
  - Stimulus: mult with valid=0.
  - Required: start=0, no busy.
  - Stimulus: mtlo 0xCAFEBABE, then mflo next cycle.
  - Required: hilo_out=0xCAFEBABE.
- Configuration check:
  - With `MDU_MADD_EN`, stimulus: HI=0, LO=0xFFFFFFFF, then maddu 1×1.
  - Required: after 5 busy cycles, HI=1, LO=0.
  - Without the macro, the same stimulus gives start=0 and HI/LO unchanged.
